// File: rtl/seg_scan_bcd_display.sv
// Multiplexed seven-segment controller fed by a sequential shift-add-3 binary-to-BCD converter.
// Optional macro SEG_BRIGHTNESS_EN adds brightness[2:0], which shortens each digit's an pulse.
module seg_scan_bcd_display #(
    parameter int N_DIGITS = 8,
    parameter int GROUPS   = 2,
    parameter int VAL_W    = 32,
    parameter int SCAN_DIV = 50000,
    parameter int CONV_D   = (VAL_W*3)/10+1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [VAL_W-1:0]                value_in,
    input  logic                            value_valid,
    output logic                            value_ready,
    input  logic [$clog2(N_DIGITS+1)-1:0]   dp_pos,
    input  logic                            blank_lz,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [2:0]                      brightness,
`endif
    output logic                            ovf,
    output logic [8*GROUPS-1:0]             seg,
    output logic [N_DIGITS-1:0]             an
);
    localparam int DPG = N_DIGITS / GROUPS;
    localparam int IW  = $clog2(N_DIGITS+1);
    localparam int PW  = $clog2(SCAN_DIV);
    localparam int CW  = $clog2(VAL_W);
    localparam int BW  = CONV_D*4;
    localparam int DW  = N_DIGITS*4;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV-1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS-1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(VAL_W-1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t                state_q, state_d;
    logic                  started_q;
    logic [VAL_W-1:0]      shift_q, shift_d;
    logic [BW-1:0]         bcd_q, bcd_d, bcdAdj;
    logic [CW-1:0]         bitCnt_q, bitCnt_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic                  ovf_q, ovf_d, hiNonZero;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         scanIdx_q, scanIdx_d;
    logic [8*GROUPS-1:0]   seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [3:0]            digit;
    logic [7:0]            pattern;
    logic                  upperZero, blank, anEnable;

    function automatic logic [7:0] segPattern(input logic [3:0] d);
        case (d)
            4'd0:    segPattern = 8'h3F;
            4'd1:    segPattern = 8'h06;
            4'd2:    segPattern = 8'h5B;
            4'd3:    segPattern = 8'h4F;
            4'd4:    segPattern = 8'h66;
            4'd5:    segPattern = 8'h6D;
            4'd6:    segPattern = 8'h7D;
            4'd7:    segPattern = 8'h07;
            4'd8:    segPattern = 8'h7F;
            4'd9:    segPattern = 8'h6F;
            default: segPattern = 8'h00;
        endcase
    endfunction

    // started_q keeps value_ready low until the first clock after reset release
    assign value_ready = started_q && (state_q == IDLE);
    assign ovf = ovf_q;
    assign seg = seg_q;
    assign an  = an_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            shift_q   <= '0;
            bcd_q     <= '0;
            bitCnt_q  <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            presc_q   <= '0;
            scanIdx_q <= '0;
            seg_q     <= '0;
            an_q      <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            bitCnt_q  <= bitCnt_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            presc_q   <= presc_d;
            scanIdx_q <= scanIdx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        bitCnt_d  = bitCnt_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        bcdAdj    = bcd_q;
        hiNonZero = 1'b0;
        for (int i = 0; i < CONV_D; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            if (i >= N_DIGITS && bcd_q[i*4 +: 4] != 4'd0)
                hiNonZero = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (value_ready && value_valid) begin
                    shift_d  = value_in;
                    bcd_d    = '0;
                    bitCnt_d = '0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                bcd_d    = {bcdAdj[BW-2:0], shift_q[VAL_W-1]};
                shift_d  = {shift_q[VAL_W-2:0], 1'b0};
                bitCnt_d = bitCnt_q + 1'b1;
                if (bitCnt_q == BIT_LAST)
                    state_d = LOAD;
            end
            LOAD: begin
                disp_d  = bcd_q[DW-1:0];
                ovf_d   = hiNonZero;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d   = presc_q + 1'b1;
        scanIdx_d = scanIdx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            scanIdx_d = (scanIdx_q == IDX_LAST) ? '0 : scanIdx_q + 1'b1;
        end
    end

`ifdef SEG_BRIGHTNESS_EN
    assign anEnable = 32'(presc_q) < ((({29'd0, brightness} + 32'd1) * 32'(SCAN_DIV)) / 32'd8);
`else
    assign anEnable = 1'b1;
`endif

    // Next seg/an come from the current scan slot; the register adds the one-clock delay
    always_comb begin
        digit     = 4'd0;
        upperZero = 1'b1;
        seg_d     = '0;
        an_d      = '0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (IW'(j) == scanIdx_q)
                digit = disp_q[j*4 +: 4];
            if (IW'(j) >= scanIdx_q && disp_q[j*4 +: 4] != 4'd0)
                upperZero = 1'b0;
        end
        blank = blank_lz && upperZero && (scanIdx_q != '0) &&
                ((dp_pos >= IW'(N_DIGITS)) || (scanIdx_q > dp_pos));
        if (ovf_q) begin
            pattern = 8'h40;
        end else begin
            pattern = blank ? 8'h00 : segPattern(digit);
            if (scanIdx_q == dp_pos)
                pattern[7] = 1'b1;
        end
        for (int j = 0; j < N_DIGITS; j++) begin
            if (IW'(j) == scanIdx_q) begin
                seg_d[(j/DPG)*8 +: 8] = pattern;
                an_d[j]               = anEnable;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_bcd_display.sv
// Bench for seg_scan_bcd_display: decimal-arithmetic reference model checked every cycle,
// plus literal digit checks. Honours SEG_BRIGHTNESS_EN when defined.
module tb_seg_scan_bcd_display;
    localparam int N_DIGITS = 8;
    localparam int GROUPS   = 2;
    localparam int VAL_W    = 32;
    localparam int SCAN_DIV = 4;
    localparam int DPG      = N_DIGITS / GROUPS;
    localparam longint LAT  = VAL_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [VAL_W-1:0]  value_in = '0;
    logic              value_valid = 1'b0;
    logic              value_ready;
    logic [3:0]        dp_pos = 4'd8;
    logic              blank_lz = 1'b0;
    logic              ovf;
    logic [15:0]       seg;
    logic [7:0]        an;
`ifdef SEG_BRIGHTNESS_EN
    logic [2:0]        brightness = 3'd7;
`endif

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    seg_scan_bcd_display #(
        .N_DIGITS(N_DIGITS), .GROUPS(GROUPS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value_in(value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .dp_pos(dp_pos),
        .blank_lz(blank_lz),
`ifdef SEG_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .ovf(ovf),
        .seg(seg),
        .an(an)
    );

    logic [7:0] segTab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    longint          edgeCnt = 0;
    longint          readyFromEdge = 1;
    longint          pendDue = 0;
    logic            pendValid = 1'b0;
    longint unsigned pendVal = 0;
    longint unsigned dispVal = 0;
    logic [15:0]     expSeg = '0;
    logic [7:0]      expAn = '0;
    logic            expOvf = 1'b0;
    logic            expReady = 1'b0;

    function automatic longint unsigned pow10(input int k);
        longint unsigned r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic anOn(input longint n);
`ifdef SEG_BRIGHTNESS_EN
        return ((n - 1) % SCAN_DIV) < (((longint'(brightness)) + 1) * SCAN_DIV) / 8;
`else
        return (n > 0);
`endif
    endfunction

    // Reference model: decimal digits by division, scan position by counting edges since reset
    task automatic modelEdge();
        longint n = edgeCnt + 1;
        int idx, bank, d;
        logic [7:0] pat;
        logic blank;
        if (value_valid && edgeCnt >= readyFromEdge) begin
            pendValid     = 1'b1;
            pendVal       = longint'(value_in);
            pendDue       = n + LAT;
            readyFromEdge = n + LAT;
        end
        idx  = int'(((n - 1) / SCAN_DIV) % N_DIGITS);
        bank = idx / DPG;
        if (dispVal >= pow10(N_DIGITS)) begin
            pat = 8'h40;
        end else begin
            d     = int'((dispVal / pow10(idx)) % 10);
            blank = blank_lz && idx != 0 && (dispVal / pow10(idx)) == 0 &&
                    (dp_pos >= N_DIGITS || idx > int'(dp_pos));
            pat   = blank ? 8'h00 : segTab[d];
            if (idx == int'(dp_pos)) pat[7] = 1'b1;
        end
        expSeg = 16'(pat) << (8 * bank);
        expAn  = '0;
        if (anOn(n)) expAn[idx] = 1'b1;
        if (pendValid && n == pendDue) begin
            dispVal   = pendVal;
            pendValid = 1'b0;
        end
        expOvf   = dispVal >= pow10(N_DIGITS);
        expReady = n >= readyFromEdge;
        edgeCnt  = n;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            edgeCnt = 0; readyFromEdge = 1; pendValid = 1'b0; dispVal = 0;
            expSeg = '0; expAn = '0; expOvf = 1'b0; expReady = 1'b0;
        end else begin
            modelEdge();
        end
    end

    task automatic checkOutput(input logic [15:0] wSeg, input logic [7:0] wAn,
                               input logic wOvf, input logic wReady);
        vecCount++;
        if (seg !== wSeg || an !== wAn || ovf !== wOvf || value_ready !== wReady) begin
            missCount++;
            $display("[TB] FAIL cycle%0d @%0t: seg=%h an=%h ovf=%b ready=%b, required seg=%h an=%h ovf=%b ready=%b",
                     edgeCnt, $time, seg, an, ovf, value_ready, wSeg, wAn, wOvf, wReady);
        end
    endtask

    // Compare process: every cycle, half a period after the active edge
    always @(negedge clk) begin
        if (rst) checkOutput(16'h0000, 8'h00, 1'b0, 1'b0);
        else     checkOutput(expSeg, expAn, expOvf, expReady);
    end

    task automatic checkLiteral(input string name, input logic [15:0] actual, input logic [15:0] want);
        vecCount++;
        if (actual !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, want);
        end
    endtask

    task automatic expectDigit(input int idx, input logic [15:0] want, input string name);
        int k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (an !== (8'd1 << idx) && k < 80);
        if (an !== (8'd1 << idx)) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s: digit %0d never selected, an=%h", name, idx, an);
        end else begin
            checkLiteral(name, seg, want);
        end
    endtask

    task automatic waitReady(input string name);
        int k = 0;
        while (value_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (value_ready !== 1'b1) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s: value_ready stuck at %b, required 1", name, value_ready);
        end
    endtask

    task automatic applyStimulus(input logic [VAL_W-1:0] v, input logic [3:0] dp, input logic bl);
        @(posedge clk); #2;
        value_in    = v;
        value_valid = 1'b1;
        dp_pos      = dp;
        blank_lz    = bl;
        @(posedge clk); #2;
        value_valid = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        checkLiteral("readyInReleaseCycle", {15'd0, value_ready}, 16'd0);
        @(negedge clk); #1;
        checkLiteral("readyAfterRelease", {15'd0, value_ready}, 16'd1);
        checkLiteral("anAfterRelease", {8'd0, an}, 16'h0001);
        checkLiteral("segAfterRelease", seg, 16'h003F);
    endtask

    initial begin
        // Idle scan after reset shows zeros
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        checkLiteral("readyBeforeFirstClk", {15'd0, value_ready}, 16'd0);
        checkLiteral("anBeforeFirstClk", {8'd0, an}, 16'h0000);
        expectDigit(4, 16'h3F00, "idleDigit4");
        expectDigit(7, 16'h3F00, "idleDigit7");
        expectDigit(2, 16'h003F, "idleDigit2");
        checkLiteral("idleOvf", {15'd0, ovf}, 16'd0);

        // Eight-digit value, no dp
        waitReady("ready12345678");
        applyStimulus(32'd12345678, 4'd8, 1'b0);
        repeat (40) @(posedge clk);
        expectDigit(0, 16'h007F, "val8Digit0");
        expectDigit(3, 16'h006D, "val8Digit3");
        expectDigit(4, 16'h6600, "val8Digit4");
        expectDigit(7, 16'h0600, "val8Digit7");

        // Leading-zero blanking with dp on digit 2
        waitReady("ready305");
        applyStimulus(32'd305, 4'd2, 1'b1);
        repeat (40) @(posedge clk);
        expectDigit(0, 16'h006D, "blankDigit0");
        expectDigit(1, 16'h003F, "blankDigit1");
        expectDigit(2, 16'h00CF, "blankDigit2");
        expectDigit(3, 16'h0000, "blankDigit3");
        expectDigit(6, 16'h0000, "blankDigit6");

        // Overflow shows dashes regardless of dp/blanking, then clears
        waitReady("readyOvf");
        applyStimulus(32'd100000000, 4'd0, 1'b1);
        repeat (40) @(posedge clk);
        checkLiteral("ovfSet", {15'd0, ovf}, 16'd1);
        expectDigit(0, 16'h0040, "ovfDigit0");
        expectDigit(5, 16'h4000, "ovfDigit5");
        waitReady("ready7");
        applyStimulus(32'd7, 4'd8, 1'b0);
        repeat (40) @(posedge clk);
        checkLiteral("ovfClear", {15'd0, ovf}, 16'd0);
        expectDigit(0, 16'h0007, "sevenDigit0");
        expectDigit(1, 16'h003F, "sevenDigit1");

        // Offer while busy is dropped
        waitReady("ready42");
        applyStimulus(32'd42, 4'd8, 1'b0);
        repeat (4) @(posedge clk);
        applyStimulus(32'd99, 4'd8, 1'b0);
        repeat (45) @(posedge clk);
        expectDigit(0, 16'h005B, "busyDigit0");
        expectDigit(1, 16'h0066, "busyDigit1");

        // Reset in the middle of a conversion
        waitReady("ready77");
        applyStimulus(32'd77, 4'd8, 1'b0);
        repeat (10) @(posedge clk);
        pulseReset();
        repeat (45) @(posedge clk);
        expectDigit(0, 16'h003F, "abortDigit0");
        expectDigit(1, 16'h003F, "abortDigit1");

`ifdef SEG_BRIGHTNESS_EN
        begin
            int onCount = 0;
            @(posedge clk); #2 brightness = 3'd3;
            repeat (40) @(posedge clk);
            for (int c = 0; c < N_DIGITS * SCAN_DIV; c++) begin
                @(negedge clk); #1;
                if (an != 8'h00) onCount++;
            end
            checkLiteral("brightnessOnCycles", 16'(onCount), 16'd16);
            @(posedge clk); #2 brightness = 3'd7;
            repeat (10) @(posedge clk);
        end
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
